// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi loopback frame controller.
package viterbi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    TAIL,
    FLUSH,
    DONE
  } state_t;

  typedef struct packed {
    logic tag;
    logic ref_bit;
  } ref_ent_t;

  // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [1:0]  INJ_MASK     = 2'b10;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/viterbi_ref_pipe.sv
// Latency-matching delay line of {tag, ref_bit} with synchronous clear.
module viterbi_ref_pipe
  import viterbi_pkg::*;
#(
  parameter int unsigned DEPTH = 5
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clr,
  input  ref_ent_t d,
  output ref_ent_t q
);

  ref_ent_t [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q <= '0;
    end else if (clr) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= {pipe_q[DEPTH-2:0], d};
    end
  end

  assign q = pipe_q[DEPTH-1];

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer/checker for the Viterbi loopback.
// Define VITERBI_CTRL_ERR_INJ_EN to enable periodic error injection.
module viterbi_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int unsigned FRAME_LEN  = 256,
  parameter int unsigned TAIL_LEN   = 2,
  parameter int unsigned DEC_LAT    = 16,
  parameter int unsigned INJ_PERIOD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [15:0] seed_i,
  input  logic        dec_bit_i,
  output logic        enc_en_o,
  output logic        enc_bit_o,
  output logic [1:0]  err_mask_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] bit_err_ct_o,
  output logic [15:0] inj_ct_o
);

  localparam logic [31:0] PAY_LAST   = 32'(FRAME_LEN) - 32'd1;
  localparam logic [31:0] TAIL_LAST  = 32'(TAIL_LEN) - 32'd1;
  localparam logic [31:0] FLUSH_LAST = 32'(DEC_LAT);

  state_t      state_q;
  logic [31:0] cnt_q;
  logic [15:0] lfsr_q;
  logic [15:0] seed_eff;
  logic        start_acc;
  ref_ent_t    pipe_d;
  ref_ent_t    pipe_q;

  assign seed_eff  = (seed_i == 16'h0000) ? DEFAULT_SEED : seed_i;
  assign start_acc = (state_q == IDLE) && start_i && !abort_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lfsr_q    <= DEFAULT_SEED;
      enc_en_o  <= 1'b0;
      enc_bit_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else if (abort_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      enc_en_o  <= 1'b0;
      enc_bit_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q   <= PAYLOAD;
            cnt_q     <= '0;
            lfsr_q    <= lfsr_next(seed_eff);
            enc_en_o  <= 1'b1;
            enc_bit_o <= seed_eff[0];
            busy_o    <= 1'b1;
          end
        end
        PAYLOAD: begin
          if (cnt_q == PAY_LAST) begin
            cnt_q     <= '0;
            enc_bit_o <= 1'b0;
            if (TAIL_LEN == 0) begin
              state_q  <= FLUSH;
              enc_en_o <= 1'b0;
            end else begin
              state_q  <= TAIL;
            end
          end else begin
            cnt_q     <= cnt_q + 32'd1;
            enc_bit_o <= lfsr_q[0];
            lfsr_q    <= lfsr_next(lfsr_q);
          end
        end
        TAIL: begin
          if (cnt_q == TAIL_LAST) begin
            state_q  <= FLUSH;
            cnt_q    <= '0;
            enc_en_o <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        FLUSH: begin
          if (cnt_q == FLUSH_LAST) begin
            state_q <= DONE;
            cnt_q   <= '0;
            done_o  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Only payload bits carry a tag; the tail is encoded but never checked.
  assign pipe_d = '{tag: (state_q == PAYLOAD), ref_bit: enc_bit_o};

  viterbi_ref_pipe #(
    .DEPTH(DEC_LAT + 1)
  ) u_ref_pipe (
    .clk(clk),
    .rst(rst),
    .clr(abort_i),
    .d  (pipe_d),
    .q  (pipe_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_err_ct_o <= '0;
    end else if (start_acc) begin
      bit_err_ct_o <= '0;
    end else if (!abort_i && pipe_q.tag && (pipe_q.ref_bit != dec_bit_i)) begin
      bit_err_ct_o <= sat_inc(bit_err_ct_o);
    end
  end

`ifdef VITERBI_CTRL_ERR_INJ_EN
  localparam logic [31:0] INJ_LAST = 32'(INJ_PERIOD) - 32'd1;

  logic [31:0] phase_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q    <= '0;
      err_mask_o <= '0;
      inj_ct_o   <= '0;
    end else if (abort_i) begin
      err_mask_o <= '0;
    end else if (start_acc) begin
      phase_q    <= '0;
      err_mask_o <= '0;
      inj_ct_o   <= '0;
    end else if (enc_en_o) begin
      if (phase_q == INJ_LAST) begin
        phase_q    <= '0;
        err_mask_o <= INJ_MASK;
        inj_ct_o   <= sat_inc(inj_ct_o);
      end else begin
        phase_q    <= phase_q + 32'd1;
        err_mask_o <= '0;
      end
    end else begin
      err_mask_o <= '0;
    end
  end
`else
  assign err_mask_o = 2'b00;
  assign inj_ct_o   = 16'h0000;
`endif

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed self-checking bench for viterbi_frame_ctrl (FRAME_LEN=8, TAIL_LEN=2,
// DEC_LAT=4, INJ_PERIOD=4) with the decoder modelled as an ideal delay.
module tb_viterbi_frame_ctrl;

  localparam int DEC_LAT = 4;

`ifdef VITERBI_CTRL_ERR_INJ_EN
  localparam logic [31:0] EXP_INJ  = 32'd2;
  localparam logic [31:0] EXP_MASK = 32'h0000_0220;
`else
  localparam logic [31:0] EXP_INJ  = 32'd0;
  localparam logic [31:0] EXP_MASK = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [15:0] seed_i = '0;
  logic        dec_bit_i;
  logic        enc_en_o;
  logic        enc_bit_o;
  logic [1:0]  err_mask_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] bit_err_ct_o;
  logic [15:0] inj_ct_o;

  viterbi_frame_ctrl #(
    .FRAME_LEN (8),
    .TAIL_LEN  (2),
    .DEC_LAT   (DEC_LAT),
    .INJ_PERIOD(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .seed_i      (seed_i),
    .dec_bit_i   (dec_bit_i),
    .enc_en_o    (enc_en_o),
    .enc_bit_o   (enc_bit_o),
    .err_mask_o  (err_mask_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .bit_err_ct_o(bit_err_ct_o),
    .inj_ct_o    (inj_ct_o)
  );

  always #5 clk = ~clk;

  // Ideal decoder: bit sent in cycle c reappears in cycle c+1+DEC_LAT,
  // optionally inverted for selected encoder-cycle indices.
  logic [DEC_LAT:0] hist = '0;
  int               idx_h [DEC_LAT+1];
  int               ec = 0;
  logic [15:0]      flip_mask = '0;
  logic             flip;

  always @(posedge clk) begin
    hist <= {hist[DEC_LAT-1:0], enc_bit_o};
    idx_h[0] <= enc_en_o ? ec : -1;
    for (int i = 1; i <= DEC_LAT; i++) idx_h[i] <= idx_h[i-1];
    if (!busy_o) ec <= 0;
    else if (enc_en_o) ec <= ec + 1;
  end

  always_comb begin
    flip = 1'b0;
    if (idx_h[DEC_LAT] >= 0 && idx_h[DEC_LAT] < 16)
      flip = flip_mask[idx_h[DEC_LAT][3:0]];
    dec_bit_i = hist[DEC_LAT] ^ flip;
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int          r_en;
  logic [7:0]  r_bits;
  int          r_done;
  logic [31:0] r_mask;
  logic [31:0] r_busy;
  logic [31:0] r_ct1;
  logic        r_rstz;

  // Start a frame at edge t, then watch cycles t+1..t+20.
  task automatic frame(input logic [15:0] seed, input int ab,
                       input int s1, input int s2, input int s3,
                       input int rn);
    r_en = 0; r_bits = '0; r_done = 0; r_mask = '0;
    r_busy = '0; r_ct1 = '1; r_rstz = 1'b0;
    @(negedge clk);
    seed_i = seed;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      start_i = (n == s1) || (n == s2) || (n == s3);
      abort_i = (n == ab);
      rst = (n != rn);
      @(negedge clk);
      if (enc_en_o && n <= 16) begin
        if (r_en < 8) r_bits[r_en] = enc_bit_o;
        r_en++;
      end
      if (done_o && r_done == 0) r_done = n;
      if (err_mask_o == 2'b10 && n < 32) r_mask[n] = 1'b1;
      r_busy[n] = busy_o;
      if (n == 1) r_ct1 = {inj_ct_o, bit_err_ct_o};
      if (n == rn)
        r_rstz = ({enc_en_o, enc_bit_o, err_mask_o, busy_o, done_o,
                   bit_err_ct_o, inj_ct_o} == '0);
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outs", {enc_en_o, enc_bit_o, err_mask_o, busy_o, done_o},
        32'd0);
    chk("reset_cts", {inj_ct_o, bit_err_ct_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Clean frame, seed 1: first 8 payload bits are the seed LSBs.
    frame(16'h0001, 0, 0, 0, 0, 0);
    chk("a_en_cycles", r_en, 32'd10);
    chk("a_bits", r_bits, 32'h01);
    chk("a_done_at", r_done, 32'd16);
    chk("a_busy_16", r_busy[16], 32'd1);
    chk("a_busy_17", r_busy[17], 32'd0);
    chk("a_mask", r_mask, EXP_MASK);
    chk("a_bit_err", bit_err_ct_o, 32'd0);
    chk("a_inj", inj_ct_o, EXP_INJ);

    // Payload bits 2 and 5 corrupted, tail bit 8 corrupted (ignored).
    flip_mask = 16'h0124;
    frame(16'h00A5, 0, 0, 0, 0, 0);
    chk("b_bits", r_bits, 32'hA5);
    chk("b_done_at", r_done, 32'd16);
    chk("b_bit_err", bit_err_ct_o, 32'd2);
    chk("b_inj", inj_ct_o, EXP_INJ);

    // Abort in payload cycle 3.
    flip_mask = 16'h0000;
    frame(16'h1234, 3, 0, 0, 0, 0);
    chk("c_ct_cleared", r_ct1, 32'd0);
    chk("c_busy_3", r_busy[3], 32'd1);
    chk("c_busy_4", r_busy[4], 32'd0);
    chk("c_no_done", r_done, 32'd0);
    chk("c_bit_err", bit_err_ct_o, 32'd0);

    // Abort in flush after errors were counted: counters hold.
    flip_mask = 16'h0024;
    frame(16'h00A5, 13, 0, 0, 0, 0);
    chk("d_busy_14", r_busy[14], 32'd0);
    chk("d_no_done", r_done, 32'd0);
    repeat (5) @(negedge clk);
    chk("d_bit_err_hold", bit_err_ct_o, 32'd2);
    chk("d_inj_hold", inj_ct_o, EXP_INJ);

    // Seed 0 maps to ACE1; starts in FLUSH and DONE ignored, next accepted.
    flip_mask = 16'h0000;
    frame(16'h0000, 0, 13, 16, 17, 0);
    chk("e_ct_cleared", r_ct1, 32'd0);
    chk("e_bits", r_bits, 32'hE1);
    chk("e_done_at", r_done, 32'd16);
    chk("e_busy_17", r_busy[17], 32'd0);
    chk("e_busy_18", r_busy[18], 32'd1);
    repeat (30) @(negedge clk);
    chk("e2_busy_end", busy_o, 32'd0);
    chk("e2_bit_err", bit_err_ct_o, 32'd0);

    // Reset mid-tail, then a fresh frame must be identical.
    frame(16'h5A3C, 0, 0, 0, 0, 9);
    chk("f_rst_zero", r_rstz, 32'd1);
    chk("f_no_done", r_done, 32'd0);
    frame(16'h5A3C, 0, 0, 0, 0, 0);
    chk("g_en_cycles", r_en, 32'd10);
    chk("g_bits", r_bits, 32'h3C);
    chk("g_done_at", r_done, 32'd16);
    chk("g_mask", r_mask, EXP_MASK);
    chk("g_bit_err", bit_err_ct_o, 32'd0);
    chk("g_inj", inj_ct_o, EXP_INJ);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/viterbi_frame_ctrl.md
# viterbi_frame_ctrl

Frame sequencer and checker for the Viterbi encoder/decoder loopback. It generates a pseudo-random payload frame and drives the convolutional encoder's enable and data inputs, appending a zero tail. It schedules periodic single-bit error injection on the encoded symbols and compares decoder output against a latency-matched copy of the payload, reporting bit-error and injection counts. It sits above the encoder, error-injection register and decoder, replacing free-running testbench stimulus with a deterministic, restartable frame.

## Interface
Parameters:
- FRAME_LEN, 256: payload bits per frame (2..65535)
- TAIL_LEN, 2: zero tail bits (constraint length − 1), ≥0
- DEC_LAT, 16: cycles from a registered encoder symbol to its decoded bit at dec_bit_i, ≥1
- INJ_PERIOD, 8: one injected symbol every INJ_PERIOD encoder cycles, ≥2

Ports (reset rst, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst  in  1  async active-low reset
- start_i  in  1  start a frame; sampled only in IDLE
- abort_i  in  1  synchronous abort; returns to IDLE, no done_o
- seed_i  in  16  LFSR seed, captured on start acceptance
- dec_bit_i  in  1  decoder output bit
- enc_en_o  out  1  encoder enable
- enc_bit_o  out  1  encoder data bit
- err_mask_o  out  2  XOR mask applied by the datapath to the registered encoder symbol
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse at frame end
- bit_err_ct_o  out  16  payload bits where dec_bit_i ≠ reference
- inj_ct_o  out  16  symbols injected this frame

## Operation
- FSM: IDLE → PAYLOAD → TAIL → FLUSH → DONE → IDLE.
- IDLE: start_i=1 → PAYLOAD. Captures the seed (seed 0 replaced by 16'hACE1) and clears both counters and the injection phase counter.
- PAYLOAD: FRAME_LEN cycles with enc_en_o=1 and enc_bit_o=lfsr[0]. LFSR (Fibonacci, x^16+x^14+x^13+x^11+1) advances each cycle. → TAIL (or FLUSH if TAIL_LEN=0).
- TAIL: TAIL_LEN cycles with enc_en_o=1 and enc_bit_o=0. → FLUSH.
- FLUSH: enc_en_o=0 for DEC_LAT+1 cycles, draining the compare pipe. → DONE.
- DONE: done_o=1 for one cycle → IDLE. Counters hold until the next accepted start.
- Compare pipe: DEC_LAT+1-deep shift of {tag, ref_bit}. Tag=1 only for PAYLOAD cycles. When the tagged entry exits, a mismatch with dec_bit_i increments bit_err_ct_o. Tail bits are never compared.
- Injection: a phase counter runs over enc_en_o cycles, wrapping at INJ_PERIOD. On phase INJ_PERIOD−1, the next cycle's err_mask_o=2'b10 and inj_ct_o increments.
- Both counters saturate at 16'hFFFF.
- abort_i beats all transitions: goes to IDLE the next cycle, clears the pipe, holds counters, and suppresses done_o. start_i outside IDLE is ignored.

## Timing
- Reset values: enc_en_o=0, enc_bit_o=0, err_mask_o=0, busy_o=0, done_o=0, counters=0, FSM=IDLE, pipe cleared. Reset mid-frame aborts immediately.
- start_i sampled at edge t gives enc_en_o=1 from t+1 for exactly FRAME_LEN+TAIL_LEN cycles, all outputs registered.
- err_mask_o lags the corresponding enc_en_o cycle by 1, aligned to the registered encoder symbol.
- Payload bit k (sent at cycle t+1+k) is compared against dec_bit_i at cycle t+2+k+DEC_LAT.
- done_o is asserted at cycle t+1+FRAME_LEN+TAIL_LEN+DEC_LAT+1. busy_o falls the cycle after done_o.
- start_i in the cycle done_o is high is ignored. A new start is accepted the following cycle.

## Configuration
- VITERBI_CTRL_ERR_INJ_EN defined: injection scheduling as above.
- Undefined: err_mask_o tied to 2'b00, inj_ct_o tied to 0, phase counter removed. The expected result of a clean loopback is bit_err_ct_o=0.

## Structure
- Package viterbi_pkg: FSM state enum (IDLE, PAYLOAD, TAIL, FLUSH, DONE), LFSR taps, default seed 16'hACE1, inject mask constant 2'b10.
- Sub-module viterbi_ref_pipe: parameterized DEC_LAT+1 delay line of {tag, bit} with flush-clear.

## Test plan
Bench settings: FRAME_LEN=8, TAIL_LEN=2, DEC_LAT=4, INJ_PERIOD=4, decoder modelled as an ideal delay.
- Start, seed 16'h0001, macro undefined, ideal decoder → enc_en_o high 10 cycles, done_o at start+16, bit_err_ct_o=0, inj_ct_o=0.
- Same, macro defined → err_mask_o=2'b10 at enc cycles 4 and 8 (1-lag), inj_ct_o=2; ideal decoder corrects → bit_err_ct_o=0.
- Decoder model flips payload bits 2 and 5 → bit_err_ct_o=2. A flip during tail compare windows → no count.
- abort_i in PAYLOAD cycle 3 → IDLE next cycle, no done_o, counters hold; a new start clears them.
- start_i during FLUSH and during the done_o cycle → ignored. Start one cycle later → accepted. Seed 0 produces the same sequence as 16'hACE1.
- rst deasserted-asserted mid-TAIL → all outputs 0, FSM IDLE, next frame bit-identical to a fresh run.
